// File: rtl/fadd_pipe.sv
// Three-stage pipelined floating-point add/subtract with a valid/ready handshake and tag passthrough.
// Stages: S1 align, S2 add/sub + leading-zero count, S3 normalise/round/pack into the output registers.
module fadd_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] x1,
    input  logic [EXP_W+MAN_W:0] x2,
    input  logic                 sub,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] y,
    output logic                 ovf,
    output logic                 unf,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int AW = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int SW = AW + 1;             // plus carry-out of the adder
    localparam int LW = $clog2(SW + 1);
    localparam int EW = ((EXP_W > LW) ? EXP_W : LW) + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EW-1:0]    SH_MAX   = EW'(MAN_W + 3);
    localparam logic [EW-1:0]    EXP_OVF  = EW'((1 << EXP_W) - 1);

    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // ---------------- S1: unpack, specials, swap and align ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff;
    logic [MAN_W-1:0] fa, fb;
    logic [MAN_W:0]   ma, mb;
    logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, a_big;

    assign sa     = x1[W-1];
    assign sb     = x2[W-1] ^ sub;
    assign ea     = x1[W-2:MAN_W];
    assign eb     = x2[W-2:MAN_W];
    assign fa     = x1[MAN_W-1:0];
    assign fb     = x2[MAN_W-1:0];
    assign ea_eff = (ea == '0) ? EXP_W'(1) : ea;
    assign eb_eff = (eb == '0) ? EXP_W'(1) : eb;
    assign ma     = {ea != '0, fa};
    assign mb     = {eb != '0, fb};
    assign nan_a  = (ea == EXP_ONES) && (fa != '0);
    assign nan_b  = (eb == EXP_ONES) && (fb != '0);
    assign inf_a  = (ea == EXP_ONES) && (fa == '0);
    assign inf_b  = (eb == EXP_ONES) && (fb == '0);
    assign zero_a = (x1[W-2:0] == '0);
    assign zero_b = (x2[W-2:0] == '0);
    // Exponent-then-fraction ordering of the raw fields is magnitude order.
    assign a_big  = (x1[W-2:0] >= x2[W-2:0]);

    logic             c1_spec;
    logic [W-1:0]     c1_spec_y;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        c1_spec   = 1'b1;
        c1_spec_y = '0;
        if (nan_a || nan_b)
            c1_spec_y = QNAN;
        else if (inf_a && inf_b)
            c1_spec_y = (sa == sb) ? {sa, EXP_ONES, {MAN_W{1'b0}}} : QNAN;
        else if (inf_a)
            c1_spec_y = {sa, EXP_ONES, {MAN_W{1'b0}}};
        else if (inf_b)
            c1_spec_y = {sb, EXP_ONES, {MAN_W{1'b0}}};
        else if (zero_a && zero_b)
            c1_spec_y = {sa & sb, {(W-1){1'b0}}};
        else if (zero_b)
            c1_spec_y = x1;
        else if (zero_a)
            c1_spec_y = {sb, x2[W-2:0]};
        else
            c1_spec = 1'b0;
    end

    logic             c1_sign;
    logic [EXP_W-1:0] c1_exp, c1_dist;
    logic [EW-1:0]    dist_w;
    logic [MAN_W:0]   sml_m;
    logic [AW-1:0]    c1_mb, c1_ms, sml_ext, lost_mask;

    always_comb begin
        c1_sign   = a_big ? sa : sb;
        c1_exp    = a_big ? ea_eff : eb_eff;
        c1_mb     = {(a_big ? ma : mb), 3'b000};
        sml_m     = a_big ? mb : ma;
        c1_dist   = a_big ? (ea_eff - eb_eff) : (eb_eff - ea_eff);
        dist_w    = {{(EW-EXP_W){1'b0}}, c1_dist};
        sml_ext   = {sml_m, 3'b000};
        lost_mask = ~({AW{1'b1}} << c1_dist);
        // Far enough right that only the sticky bit can survive.
        if (dist_w >= SH_MAX)
            c1_ms = {{(AW-1){1'b0}}, |sml_m};
        else
            c1_ms = (sml_ext >> c1_dist) | {{(AW-1){1'b0}}, |(sml_ext & lost_mask)};
    end

    logic             s1_valid, s1_spec, s1_sign, s1_eff_sub;
    logic [W-1:0]     s1_spec_y;
    logic [EXP_W-1:0] s1_exp;
    logic [AW-1:0]    s1_mb, s1_ms;
    logic [TAG_W-1:0] s1_tag;

    // ---------------- S2: add/subtract and leading-zero count ----------------
    logic [SW-1:0] c2_sum;
    logic [LW-1:0] c2_lzc;

    always_comb begin
        if (s1_eff_sub)
            c2_sum = {1'b0, s1_mb} - {1'b0, s1_ms};
        else
            c2_sum = {1'b0, s1_mb} + {1'b0, s1_ms};
        c2_lzc = LW'(SW);
        for (int i = 0; i < SW; i++)
            if (c2_sum[i]) c2_lzc = LW'(SW - 1 - i);
    end

    logic             s2_valid, s2_spec, s2_sign;
    logic [W-1:0]     s2_spec_y;
    logic [EXP_W-1:0] s2_exp;
    logic [SW-1:0]    s2_sum;
    logic [LW-1:0]    s2_lzc;
    logic [TAG_W-1:0] s2_tag;

    // ---------------- S3: normalise, round to nearest even, pack ----------------
    logic [EW-1:0]    c3_exp_n, c3_exp_r;
    logic [AW-1:0]    c3_norm;
    logic             c3_rnd, c3_ovf, c3_unf;
    logic [MAN_W+1:0] c3_mant;
    logic [MAN_W-1:0] c3_frac;
    logic [W-1:0]     c3_y;

    always_comb begin
        c3_exp_n = {{(EW-EXP_W){1'b0}}, s2_exp} + EW'(1) - {{(EW-LW){1'b0}}, s2_lzc};
        if (s2_lzc == '0) begin
            c3_norm    = AW'(s2_sum >> 1);
            c3_norm[0] = c3_norm[0] | s2_sum[0];
        end else begin
            c3_norm = AW'(s2_sum << (s2_lzc - LW'(1)));
        end
        c3_rnd  = c3_norm[2] & (c3_norm[3] | (|c3_norm[1:0]));
        c3_mant = {1'b0, c3_norm[AW-1:3]} + {{(MAN_W+1){1'b0}}, c3_rnd};
        if (c3_mant[MAN_W+1]) begin
            c3_exp_r = c3_exp_n + EW'(1);
            c3_frac  = c3_mant[MAN_W:1];
        end else begin
            c3_exp_r = c3_exp_n;
            c3_frac  = c3_mant[MAN_W-1:0];
        end
        c3_ovf = 1'b0;
        c3_unf = 1'b0;
        if (s2_spec) begin
            c3_y = s2_spec_y;
        end else if (s2_sum == '0) begin
            c3_y = '0;
        end else if (c3_exp_n[EW-1] || (c3_exp_n == '0)) begin
            c3_y   = {s2_sign, {(W-1){1'b0}}};
            c3_unf = 1'b1;
        end else if (c3_exp_r >= EXP_OVF) begin
            c3_y   = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            c3_ovf = 1'b1;
        end else begin
            c3_y = {s2_sign, c3_exp_r[EXP_W-1:0], c3_frac};
        end
    end

    // ---------------- Registers ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            out_tag   <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                y       <= c3_y;
                ovf     <= c3_ovf;
                unf     <= c3_unf;
                out_tag <= s2_tag;
            end
        end
    end

    // NOTE: stage datapath registers have no reset; they are only meaningful under their valid bit.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_spec    <= c1_spec;
            s1_spec_y  <= c1_spec_y;
            s1_sign    <= c1_sign;
            s1_eff_sub <= sa ^ sb;
            s1_exp     <= c1_exp;
            s1_mb      <= c1_mb;
            s1_ms      <= c1_ms;
            s1_tag     <= in_tag;
            s2_spec    <= s1_spec;
            s2_spec_y  <= s1_spec_y;
            s2_sign    <= s1_sign;
            s2_exp     <= s1_exp;
            s2_sum     <= c2_sum;
            s2_lzc     <= c2_lzc;
            s2_tag     <= s1_tag;
        end
    end
endmodule

// File: tb/tb_fadd_pipe.sv
// Bench for fadd_pipe: vector table through a scoreboard, stall stream, reset flush,
// and a half-precision build.
module tb_fadd_pipe;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] y;
        logic        ovf;
        logic        unf;
    } vec_t;

    typedef struct {
        logic [31:0] y;
        logic        ovf;
        logic        unf;
        logic [3:0]  tag;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    localparam int NV = 20;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, sub, out_valid, out_ready, ovf, unf;
    logic [31:0] x1, x2, y;
    logic [3:0]  in_tag, out_tag;

    logic        in_valid_h, in_ready_h, sub_h, out_valid_h, out_ready_h, ovf_h, unf_h;
    logic [15:0] x1_h, x2_h, y_h;
    logic [3:0]  in_tag_h, out_tag_h;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[NV];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   seen;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fadd_pipe dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .sub(sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf), .unf(unf),
        .out_tag(out_tag)
    );

    fadd_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_h), .in_ready(in_ready_h),
        .x1(x1_h), .x2(x2_h), .sub(sub_h), .in_tag(in_tag_h),
        .out_valid(out_valid_h), .out_ready(out_ready_h), .y(y_h), .ovf(ovf_h), .unf(unf_h),
        .out_tag(out_tag_h)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Drives one op, waits for acceptance, and records its expected result.
    task automatic send(input int idx, input logic [3:0] t, input bit lat);
        exp_t e;
        int   waited = 0;
        bit   done   = 0;
        x1 = vecs[idx].a;  x2 = vecs[idx].b;  sub = vecs[idx].s;
        in_tag = t;  in_valid = 1'b1;
        e.y = vecs[idx].y;  e.ovf = vecs[idx].ovf;  e.unf = vecs[idx].unf;
        e.tag = t;  e.chk_lat = lat;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc_cyc = cyc;
                sb_q.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
            if (!done) begin
                waited++;
                if (waited > 50) begin
                    check("accept_timeout", 1, 0);
                    done = 1;
                end
            end
        end
    endtask

    task automatic drain();
        int w = 0;
        while (sb_q.size() != 0 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    task automatic run_h(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] ey, input logic eovf);
        int w = 0;
        x1_h = a;  x2_h = b;  sub_h = s;  in_tag_h = 4'hA;  in_valid_h = 1'b1;
        @(negedge clk);
        check("h_in_ready", in_ready_h, 1);
        @(posedge clk); #1;
        in_valid_h = 1'b0;
        while (!out_valid_h && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        check("h_latency", w, 2);
        check("h_y", y_h, ey);
        check("h_ovf", ovf_h, eovf);
        check("h_tag", out_tag_h, 4'hA);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: compares the head entry every cycle out_valid is high,
    // which also proves the output holds steady while stalled.
    always @(negedge clk) begin
        if (rstn && out_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                mon_e = sb_q[0];
                check("y", y, mon_e.y);
                check("flags", {ovf, unf}, {mon_e.ovf, mon_e.unf});
                check("tag", out_tag, mon_e.tag);
                if (out_ready) begin
                    if (mon_e.chk_lat) check("latency", cyc - mon_e.acc_cyc, 3);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0};
        vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0};
        vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
        vecs[4]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 1'b0};
        vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0};
        vecs[6]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0};
        vecs[7]  = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 1'b1};
        vecs[8]  = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[9]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0};
        vecs[10] = '{32'h7F800000, 32'hC0000000, 1'b0, 32'h7F800000, 1'b0, 1'b0};
        vecs[11] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0};
        vecs[12] = '{32'h00000001, 32'h00000000, 1'b0, 32'h00000001, 1'b0, 1'b0};
        vecs[13] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[14] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 1'b0};
        vecs[15] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0};
        vecs[16] = '{32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 1'b0, 1'b0};
        vecs[17] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0};
        vecs[18] = '{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 1'b1, 1'b0};
        vecs[19] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0};

        rstn = 1'b0;  in_valid = 1'b0;  x1 = '0;  x2 = '0;  sub = 1'b0;  in_tag = '0;
        out_ready = 1'b1;
        in_valid_h = 1'b0;  x1_h = '0;  x2_h = '0;  sub_h = 1'b0;  in_tag_h = '0;
        out_ready_h = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_flags", {ovf, unf}, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_valid_h", out_valid_h, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        // Isolated ops: exact 3-cycle latency on each.
        for (int i = 0; i < NV; i++) begin
            send(i, 4'(i), 1'b1);
            in_valid = 1'b0;
            drain();
        end

        // Back-to-back at full throughput.
        for (int i = 0; i < NV; i++) send(i, 4'(i), 1'b1);
        in_valid = 1'b0;
        drain();

        // Tags 0..7 streamed while out_ready drops for cycles 4..8.
        fork
            begin
                for (int k = 0; k < 8; k++) send(k, 4'(k), 1'b0);
                in_valid = 1'b0;
            end
            begin
                for (int t = 0; t < 12; t++) begin
                    out_ready = !(t >= 4 && t <= 8);
                    @(negedge clk);
                    check("in_ready_stall", in_ready, !(t >= 4 && t <= 8));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Half-precision build.
        run_h(16'h3C00, 16'h4000, 1'b0, 16'h4200, 1'b0);
        run_h(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0);
        run_h(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1);

        // Reset with three ops in flight.
        for (int k = 0; k < 3; k++) send(k, 4'(8 + k), 1'b0);
        in_valid = 1'b0;
        check("pre_rst_out_valid", out_valid, 1);
        rstn = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_results_after_rst", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
